// File: rtl/edge_frame_packer.sv
// edge_frame_packer: captures one frame of 8-bit edge samples, packs four
// samples per 32-bit word (little-endian lanes), queues words in a small FIFO
// and writes them to frame memory over a valid/ready port with word addresses.
// Optional build macro EDGE_PACK_BINARIZE_EN maps each non-zero sample to 8'hFF
// and each zero sample to 8'h00 before packing.
//
// Write-port handshake: wr_valid is high whenever the FIFO holds a word, and
// wr_addr/wr_data show the FIFO head. A word transfers on a rising edge where
// wr_valid && wr_ready. While wr_valid && !wr_ready the head is held stable,
// and wr_valid is never dropped without a transfer.
module edge_frame_packer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 640,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              din_valid,
  input  logic [7:0]        edge_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int PIX_W = ($clog2(TOTAL + 1) < 2) ? 2 : $clog2(TOTAL + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        r_state;
  logic [PIX_W-1:0]  r_pix;
  logic [31:0]       r_pack;
  logic [ADDR_W-1:0] r_addr;
  logic              r_push;
  logic [31:0]       r_push_data;
  logic [ADDR_W-1:0] r_push_addr;
  logic              r_overflow;

  logic [31:0]       r_mem_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
  logic [PTR_W:0]    r_wptr;
  logic [PTR_W:0]    r_rptr;

  logic [7:0]        w_sample;
  logic [1:0]        w_lane;
  logic [31:0]       w_word;
  logic              w_last;
  logic              w_word_done;
  logic              w_arm;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push_ok;

`ifdef EDGE_PACK_BINARIZE_EN
  assign w_sample = (edge_data != 8'h00) ? 8'hFF : 8'h00;
`else
  assign w_sample = edge_data;
`endif

  // Lane insertion and end-of-word / end-of-frame detection
  assign w_lane      = r_pix[1:0];
  assign w_word      = r_pack | ({24'h000000, w_sample} << {w_lane, 3'b000});
  assign w_last      = (r_pix == PIX_W'(TOTAL - 1));
  assign w_word_done = (w_lane == 2'd3) || w_last;
  assign w_arm       = frame_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_pop     = wr_valid && wr_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds
  assign w_push_ok = r_push && (!w_full || w_pop);

  // Frame FSM, pixel counter, lane packing and word staging register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pix       <= '0;
      r_pack      <= '0;
      r_addr      <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_push_addr <= '0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_arm) begin
            r_state <= S_CAPTURE;
            r_pix   <= '0;
            r_pack  <= '0;
            r_addr  <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CAPTURE: begin
          if (din_valid) begin
            if (w_word_done) begin
              r_push      <= 1'b1;
              r_push_data <= w_word;
              r_push_addr <= r_addr;
              r_pack      <= '0;
              // The address is consumed even if the word is later dropped
              if (!w_last) r_addr <= r_addr + 1'b1;
            end else begin
              r_pack <= w_word;
            end
            if (w_last) r_state <= S_FLUSH;
            else        r_pix   <= r_pix + 1'b1;
          end
        end
        S_FLUSH: begin
          if (!r_push && w_empty) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky drop flag, cleared only when a new frame is armed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_arm) begin
      r_overflow <= 1'b0;
    end else if (r_push && !w_push_ok) begin
      r_overflow <= 1'b1;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
    end
  end

  // FIFO storage; contents are only visible through a non-empty head
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem_data[r_wptr[PTR_W-1:0]] <= r_push_data;
      r_mem_addr[r_wptr[PTR_W-1:0]] <= r_push_addr;
    end
  end

  assign wr_valid   = !w_empty;
  assign wr_addr    = w_empty ? '0 : r_mem_addr[r_rptr[PTR_W-1:0]];
  assign wr_data    = w_empty ? '0 : r_mem_data[r_rptr[PTR_W-1:0]];
  assign busy       = (r_state == S_CAPTURE) || (r_state == S_FLUSH);
  assign frame_done = (r_state == S_DONE);
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_edge_frame_packer.sv
// Testbench for edge_frame_packer: 6x3 frame (18 samples -> 4 full words plus
// a 2-sample partial word), 2-entry FIFO. Expected words come from a simple
// byte-list packing model and are checked by an independent write-port monitor.
module tb_edge_frame_packer;

  localparam int W     = 6;
  localparam int H     = 3;
  localparam int TOTAL = W * H;
  localparam int DEPTH = 2;
  localparam int AW    = 4;
  localparam int EW    = AW + 32;

  // Clock / reset / DUT signals
  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          din_valid;
  logic [7:0]    edge_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          frame_done;
  logic          overflow;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  int done_cnt = 0;
  int ready_mode = 1;  // 0: held low, 1: held high, 2: random with short low runs
  int low_run = 0;

  logic [EW-1:0] exp_q[$];
  logic          hold_v = 1'b0;
  logic [EW-1:0] hold_val;

  always #5 clk = ~clk;

  edge_frame_packer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .din_valid  (din_valid),
    .edge_data  (edge_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference sample mapping
  function automatic logic [7:0] bin(input logic [7:0] s);
`ifdef EDGE_PACK_BINARIZE_EN
    return (s != 8'h00) ? 8'hFF : 8'h00;
`else
    return s;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory-side ready generator; random mode never holds ready low more than
  // two cycles, so a 1-word-per-4-cycles source can never fill the FIFO
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: wr_ready = 1'b0;
      1: wr_ready = 1'b1;
      default: begin
        if (low_run >= 2) wr_ready = 1'b1;
        else              wr_ready = 1'($urandom_range(0, 1));
        low_run = wr_ready ? 0 : low_run + 1;
      end
    endcase
  end

  // Write-port monitor: pops the scoreboard on every transfer and checks that
  // a stalled head stays put
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_valid", 64'(wr_valid), 64'(1));
        check("stall_head", 64'({wr_addr, wr_data}), 64'(hold_val));
      end
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'({wr_addr, wr_data}), 64'(0));
        end else begin
          check("word", 64'({wr_addr, wr_data}), 64'(exp_q.pop_front()));
        end
      end
      hold_v   = wr_valid && !wr_ready;
      hold_val = {wr_addr, wr_data};
      if (frame_done) done_cnt++;
    end
  end

  // Drive one frame; expected words are queued as each word completes.
  // keep_all=0 models a memory that accepts nothing during capture: only the
  // first DEPTH words survive.
  task automatic send_frame(input int gap_max, input bit keep_all, input bit junk, input bit lat_chk);
    logic [7:0]  px[$];
    logic [31:0] w;
    int nword = 0;
    int g;
    int idx;
    if (junk) begin
      for (int i = 0; i < 3; i++) begin
        tick(); din_valid = 1'b1; edge_data = 8'($urandom);
      end
    end
    tick(); din_valid = 1'b0; frame_start = 1'b1;
    @(negedge clk); check("busy_before_arm", 64'(busy), 64'(0));
    tick(); frame_start = 1'b0;
    @(negedge clk); check("busy_after_arm", 64'(busy), 64'(1));
    for (int i = 0; i < TOTAL; i++) begin
      g = $urandom_range(0, gap_max);
      for (int j = 0; j < g; j++) begin
        tick(); din_valid = 1'b0;
      end
      tick();
      din_valid = 1'b1;
      if (lat_chk) edge_data = 8'(i + 1);
      else if ($urandom_range(0, 3) == 0) edge_data = 8'h00;
      else edge_data = 8'($urandom_range(1, 255));
      px.push_back(bin(edge_data));
      if ((px.size() % 4 == 0) || (i == TOTAL - 1)) begin
        w = '0;
        for (int j = 0; j < 4; j++) begin
          idx = nword * 4 + j;
          if (idx < px.size()) w[8*j +: 8] = px[idx];
        end
        if (keep_all || nword < DEPTH) exp_q.push_back({AW'(nword), w});
        nword++;
        if (lat_chk && nword == 1) begin
          fork
            begin
              @(negedge clk);
              @(negedge clk); check("latency_edge_n", 64'(wr_valid), 64'(0));
              @(negedge clk); check("latency_edge_n1", 64'(wr_valid), 64'(1));
            end
          join_none
        end
      end
    end
    tick(); din_valid = 1'b0;
    if (junk) begin
      for (int i = 0; i < 3; i++) begin
        din_valid = 1'b1; edge_data = 8'($urandom); tick();
      end
      din_valid = 1'b0;
    end
  endtask

  // Bounded wait for frame_done, then end-of-frame checks
  task automatic finish_frame(input bit exp_ovf);
    int n = 0;
    @(negedge clk);
    while (!frame_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", 64'(frame_done), 64'(1));
    if (frame_done) begin
      check("overflow_at_done", 64'(overflow), 64'(exp_ovf));
      check("busy_at_done", 64'(busy), 64'(0));
      check("valid_at_done", 64'(wr_valid), 64'(0));
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      @(negedge clk);
      check("frame_done_pulse", 64'(frame_done), 64'(0));
    end
    frames++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; din_valid = 1'b0; edge_data = 8'h00; wr_ready = 1'b0;
    ready_mode = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_wr_valid", 64'(wr_valid), 64'(0));
    check("reset_wr_addr", 64'(wr_addr), 64'(0));
    check("reset_wr_data", 64'(wr_data), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_frame_done", 64'(frame_done), 64'(0));
    check("reset_overflow", 64'(overflow), 64'(0));
    tick(); rst = 1'b0;

    // Back-to-back counting samples, memory always ready
    send_frame(0, 1'b1, 1'b0, 1'b1);
    finish_frame(1'b0);

    // Stray samples before arming and after the last pixel are ignored
    send_frame(0, 1'b1, 1'b1, 1'b0);
    finish_frame(1'b0);

    // Random data, random gaps, random memory backpressure
    ready_mode = 2;
    repeat (4) begin
      send_frame(3, 1'b1, 1'b0, 1'b0);
      finish_frame(1'b0);
    end

    // Memory stalled for the whole capture: FIFO fills, later words dropped
    ready_mode = 0;
    tick(); tick();
    send_frame(1, 1'b0, 1'b0, 1'b0);
    repeat (6) tick();
    @(negedge clk);
    check("ovf_flag", 64'(overflow), 64'(1));
    check("ovf_busy", 64'(busy), 64'(1));
    check("ovf_valid", 64'(wr_valid), 64'(1));
    if (exp_q.size() > 0) check("ovf_head", 64'({wr_addr, wr_data}), 64'(exp_q[0]));
    ready_mode = 1;
    finish_frame(1'b1);

    // Arming a new frame clears the sticky flag
    send_frame(1, 1'b1, 1'b0, 1'b0);
    finish_frame(1'b0);

    // Reset in the middle of a frame with a word waiting on the port
    ready_mode = 0;
    tick(); tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din_valid = 1'b1; edge_data = 8'($urandom); tick();
    end
    din_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("pre_reset_valid", 64'(wr_valid), 64'(1));
    tick(); rst = 1'b1;
    @(negedge clk);
    check("midreset_valid", 64'(wr_valid), 64'(0));
    check("midreset_busy", 64'(busy), 64'(0));
    check("midreset_addr", 64'(wr_addr), 64'(0));
    exp_q.delete();
    tick(); rst = 1'b0; ready_mode = 1;
    send_frame(0, 1'b1, 1'b0, 1'b0);
    finish_frame(1'b0);

    tick();
    check("frame_done_count", 64'(done_cnt), 64'(frames));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_frame_packer.md
# edge_frame_packer

Sink for the edge-detection output stream: captures one frame of 8-bit `edge_data` samples qualified by `din_valid`, packs four samples per 32-bit word, buffers words in a small FIFO and writes them to frame memory over a valid/ready write port with word addresses. It sits directly downstream of `top_imgprocess` and replaces the file-dump sink used in simulation.

## Interface
- `IMG_WIDTH`, 640, pixels per line
- `IMG_HEIGHT`, 640, lines per frame
- `FIFO_DEPTH`, 16, word FIFO entries (power of 2, ≥2)
- `ADDR_W`, 17, word-address width (must hold ceil(IMG_WIDTH*IMG_HEIGHT/4))

- `clk` in 1 system clock, all logic on rising edge
- `rst` in 1 asynchronous, active-high reset
- `frame_start` in 1 single-cycle pulse arming capture of next frame
- `din_valid` in 1 qualifies `edge_data`
- `edge_data` in 8 edge magnitude sample
- `wr_valid` out 1 write request
- `wr_ready` in 1 memory accepts write
- `wr_addr` out ADDR_W word address, 0 = first word of frame
- `wr_data` out 32 packed samples
- `busy` out 1 high from armed until frame done
- `frame_done` out 1 single-cycle pulse, whole frame written
- `overflow` out 1 sticky, a word was dropped this frame

## Operation
- States: IDLE, CAPTURE, FLUSH, DONE.
- IDLE: `din_valid` ignored. `frame_start` → CAPTURE; clears pixel count, lane index, write address, `overflow`.
- CAPTURE: each `din_valid` sample goes into byte lane = pixel_count mod 4; lane 0 = bits [7:0] (first pixel, little-endian). 4th lane completes a word → pushed to FIFO. After pixel IMG_WIDTH*IMG_HEIGHT-1 accepted → FLUSH. A partial final word is pushed with unused lanes zero.
- FLUSH: further `din_valid` ignored; waits until FIFO empty → DONE.
- DONE: `frame_done` high one cycle → IDLE.
- `frame_start` while `busy` is ignored.
- No input backpressure. Word completing while FIFO full: word dropped, `overflow` set, its address still consumed (later words keep correct addresses).
- Pixel count and address wrap never occur: counters stop at end of frame.
- Push and pop in same cycle on a full FIFO: pop frees space, push succeeds, no overflow.
- Write port: `wr_valid` = FIFO non-empty; `wr_addr`/`wr_data` = FIFO head. Transfer on `wr_valid && wr_ready`. While `wr_valid && !wr_ready`, outputs held stable. `wr_valid` never withdrawn without transfer.
- Reset (any time, including mid-frame): FIFO emptied, state IDLE, all counters zero.

## Timing
- Reset values: `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `frame_done`=0, `overflow`=0.
- `busy` rises the cycle after `frame_start` sampled; falls with `frame_done`.
- Word-completing sample sampled at edge N → FIFO write at edge N+1 → `wr_valid` high after edge N+1 (FIFO previously empty): 2-cycle latency.
- Sustained throughput: 1 word/cycle out, input max 1 sample/cycle (≤¼ port bandwidth used).
- `frame_done` asserted the cycle after the last FIFO pop, FIFO empty, in FLUSH.
- `overflow` sets the cycle after the drop; cleared only by accepted `frame_start` or `rst`.

## Configuration
- `EDGE_PACK_BINARIZE_EN` defined: each sample mapped to 8'hFF if non-zero else 8'h00 before packing.
- Not defined: samples packed unmodified.

## Test plan
- IMG_WIDTH=4, IMG_HEIGHT=2, `wr_ready`=1: `frame_start`, samples 01..08 back-to-back → words 0x04030201 @0, 0x08070605 @1; `frame_done` one pulse; `overflow`=0.
- IMG_WIDTH=3, IMG_HEIGHT=1: samples AA,BB,CC → single word 0x00CCBBAA @0, then `frame_done`.
- FIFO_DEPTH=2, 4×2 frame ×2 (16 samples), `wr_ready`=0 throughout capture: words 0,1 held stable, words 2,3 dropped, `overflow`=1; release `wr_ready` → addresses 0,1 written, `frame_done`.
- `din_valid` pulses before `frame_start` and after last pixel → ignored; output identical to first scenario.
- Assert `rst` mid-frame after 5 samples with `wr_valid` high → next cycle `wr_valid`=0, `busy`=0; new `frame_start` restarts at address 0.
- With `EDGE_PACK_BINARIZE_EN`, samples 00,05,00,96 → word 0xFF00FF00.
